// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter slice.
//   arb_state_e        : arbiter FSM states (IDLE=0, BURST=1)
//   clog2()            : ceiling log2, usable in parameter expressions
//   FIFO_WIDTH_DEFAULT : data width default, shared with FIFO_SYNC
package fifo_arb_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotating-priority picker.
//   req_i    : request vector
//   start_i  : first index examined; search continues start_i+1, ... mod NUM_REQ
//   onehot_o : one-hot of the selected request (zero when none)
//   idx_o    : index of the selected request (zero when none)
//   any_o    : at least one request present
module fifo_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned k;
    logic [ID_W-1:0] kk;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    k        = 0;
    kk       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k  = (32'(start_i) + i) % NUM_REQ;
      kk = ID_W'(k);
      if (!any_o && req_i[kk]) begin
        any_o        = 1'b1;
        idx_o        = kk;
        onehot_o[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO_SYNC write port among NUM_REQ
// producers, with bounded burst locking (up to MAX_BURST beats per tenure).
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-producer beat valid
//   req_data    : flattened producer data, producer k at [k*FIFO_WIDTH +: FIFO_WIDTH]
//   req_ready   : one-hot (or zero) accept, beat transfers on valid&ready
//   fifo_full   : FIFO full flag; no write is issued while it is high
//   fifo_wr_en  : FIFO write enable
//   fifo_d_in   : FIFO write data (zero when not writing)
//   grant_id    : current grantee index, meaningful while grant_valid=1
//   grant_valid : a grantee exists this cycle
//   locked      : arbiter is in a burst tenure
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_W      = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_d_in,
  output logic [ID_W-1:0]               grant_id,
  output logic                          grant_valid,
  output logic                          locked
);

  localparam int unsigned CNT_W = (clog2(MAX_BURST + 1) < 1) ? 1 : clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic [ID_W-1:0]    start;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               hold;
  logic [ID_W-1:0]    owner;
  logic [NUM_REQ-1:0] owner_oh;
  logic               gv;
  logic               wr;

  logic [FIFO_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign data_arr[k] = req_data[k*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign start = (last_q == ID_W'(NUM_REQ - 1)) ? '0 : last_q + ID_W'(1);

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i    (req_valid),
    .start_i  (start),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // A burst owner that drops valid falls through to the picker in the same
  // cycle, so release costs no dead cycle.
  assign hold     = (state_q == BURST) && req_valid[last_q];
  assign owner    = hold ? last_q : pick_idx;
  assign owner_oh = hold ? (NUM_REQ'(1) << last_q) : pick_onehot;

  // All outputs are gated by rst_n so they drop combinationally on reset.
  assign gv          = rst_n & (hold | pick_any);
  assign wr          = gv & ~fifo_full;
  assign grant_valid = gv;
  assign grant_id    = gv ? owner : '0;
  assign fifo_wr_en  = wr;
  assign req_ready   = wr ? owner_oh : '0;
  assign fifo_d_in   = wr ? data_arr[owner] : '0;
  assign locked      = rst_n & (state_q == BURST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (wr) begin
      if (hold) begin
        if (cnt_inc == CNT_W'(MAX_BURST)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = BURST;
          cnt_d   = cnt_inc;
        end
      end else begin
        last_d  = owner;
        cnt_d   = CNT_W'(1);
        state_d = (MAX_BURST > 1) ? BURST : IDLE;
      end
    end else if ((state_q == BURST) && !(|req_valid)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic           fifo_full = 1'b0;

  logic [N-1:0] rdy4, rdy1;
  logic         wr4, wr1, gv4, gv1, lk4, lk1;
  logic [W-1:0] d4, d1;
  logic [1:0]   g4, g1;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy4), .fifo_full(fifo_full), .fifo_wr_en(wr4), .fifo_d_in(d4),
    .grant_id(g4), .grant_valid(gv4), .locked(lk4));

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .fifo_full(fifo_full), .fifo_wr_en(wr1), .fifo_d_in(d1),
    .grant_id(g1), .grant_valid(gv1), .locked(lk1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (one per instance) ----------------
  int m_last[2] = '{N-1, N-1};
  int m_ten[2]  = '{0, 0};      // beats taken in the current tenure, 0 = none
  int maxb[2]   = '{4, 1};

  task automatic cmp_inst(input int i, input logic wr, input logic [W-1:0] d,
                          input logic [N-1:0] rdy, input logic [1:0] gid,
                          input logic gv, input logic lk);
    int owner, k;
    bit egv, ewr, kept;
    logic [N-1:0] erdy;
    logic [W-1:0] ed;
    string p;
    p = (i == 0) ? "b4" : "b1";
    if (!rst_n) begin
      chk({p, "_rst_outputs"}, {15'd0, wr, d, rdy, gid, gv, lk}, 32'd0);
      m_last[i] = N - 1;
      m_ten[i]  = 0;
      return;
    end
    kept  = (m_ten[i] > 0) && req_valid[m_last[i]];
    owner = 0;
    egv   = 0;
    if (kept) begin
      owner = m_last[i];
      egv   = 1;
    end else begin
      for (int s = 1; s <= N; s++) begin
        k = (m_last[i] + s) % N;
        if (!egv && req_valid[k]) begin
          owner = k;
          egv   = 1;
        end
      end
    end
    ewr  = egv && !fifo_full;
    erdy = ewr ? (N'(1) << owner) : '0;
    ed   = ewr ? req_data[owner*W +: W] : '0;
    chk({p, "_wr_en"}, 32'(wr), 32'(ewr));
    chk({p, "_d_in"}, 32'(d), 32'(ed));
    chk({p, "_ready"}, 32'(rdy), 32'(erdy));
    chk({p, "_grant_valid"}, 32'(gv), 32'(egv));
    chk({p, "_locked"}, 32'(lk), 32'(m_ten[i] > 0));
    if (egv) chk({p, "_grant_id"}, 32'(gid), 32'(owner));
    if (ewr) begin
      if (kept) begin
        m_ten[i]++;
        if (m_ten[i] == maxb[i]) m_ten[i] = 0;
      end else begin
        m_last[i] = owner;
        m_ten[i]  = (maxb[i] > 1) ? 1 : 0;
      end
    end else if (m_ten[i] > 0 && req_valid == '0) begin
      m_ten[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    cmp_inst(0, wr4, d4, rdy4, g4, gv4, lk4);
    cmp_inst(1, wr1, d1, rdy1, g1, gv1, lk1);
  end

  // ---------------- FIFO_SYNC model, depth 8, fed by u4 ----------------
  logic [W-1:0] fq[$];
  logic [W-1:0] wlog[$];
  logic rd = 1'b0;
  logic nxt_full = 1'b0;

  always @(negedge clk) begin
    if (rd && fq.size() > 0) void'(fq.pop_front());
    if (wr4) begin
      chk("no_overflow", 32'(fq.size() < DEPTH), 32'd1);
      fq.push_back(d4);
      wlog.push_back(d4);
    end
    nxt_full = (fq.size() >= DEPTH);
  end

  always @(posedge clk) fifo_full <= nxt_full;

  // ---------------- producers ----------------
  int rem[N];   // beats left, -1 = unlimited
  int base[N];
  int idx[N];
  logic [1:0]   rg4[32], rg1[32];
  logic         rw4[32], rw1[32], rl4[32], rgv4[32];
  logic [W-1:0] rdat4[32];
  logic [N-1:0] rrdy4[32];

  task automatic set_prod(input int k, input int r, input int b);
    rem[k] = r; base[k] = b; idx[k] = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = (rem[k] != 0);
      req_data[k*W +: W] = W'(base[k] + idx[k]);
    end
  endtask

  // Entered and left at posedge+1; records u4/u1 outputs per cycle.
  task automatic run_cycles(input int n);
    logic [N-1:0] acc;
    for (int c = 0; c < n; c++) begin
      drive();
      @(negedge clk);
      acc = rdy4;
      if (c < 32) begin
        rg4[c] = g4; rg1[c] = g1; rw4[c] = wr4; rw1[c] = wr1;
        rl4[c] = lk4; rgv4[c] = gv4; rdat4[c] = d4; rrdy4[c] = rdy4;
      end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          idx[k]++;
          if (rem[k] > 0) rem[k]--;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) set_prod(k, 0, 0);
    rd = 1'b1;
    run_cycles(10);
  endtask

  function automatic logic [W-1:0] logat(input int i);
    return (i < wlog.size()) ? wlog[i] : 'x;
  endfunction

  logic [W-1:0] exp_burst[16] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                                  8'h05, 8'h06, 8'h07, 8'h08, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
  logic [1:0]   exp_rr1[6]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [1:0]   exp_rr4[6]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
  logic [W-1:0] exp_res[7]  = '{8'h3A, 8'h3B, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h3C};
  logic [1:0]   exp_er[4]   = '{2'd0, 2'd0, 2'd2, 2'd2};

  initial begin
    // Reset and first beat
    for (int k = 0; k < N; k++) set_prod(k, 0, 0);
    set_prod(0, 1, 8'h11);
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_en", 32'(wr4), 32'd0);
    chk("reset_ready", 32'(rdy4), 32'd0);
    chk("reset_grant_valid", 32'(gv4), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_cycles(2);
    chk("first_wr_en", 32'(rw4[0]), 32'd1);
    chk("first_d_in", 32'(rdat4[0]), 32'h11);
    chk("first_ready", 32'(rrdy4[0]), 32'b0001);
    chk("first_grant_id", 32'(rg4[0]), 32'd0);
    chk("first_single_beat", 32'(rw4[1]), 32'd0);

    // Burst rotation with MAX_BURST=4
    flush(); do_reset(); rd = 1'b1; wlog.delete();
    set_prod(0, 8, 8'h01); set_prod(1, 8, 8'hA0);
    run_cycles(20);
    chk("burst_count", 32'(wlog.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("burst_seq", 32'(logat(i)), 32'(exp_burst[i]));
    chk("burst_unlocked_first", 32'(rl4[0]), 32'd0);
    chk("burst_locked", 32'(rl4[1]), 32'd1);

    // Pure round-robin (u1) under all-valid
    flush(); do_reset(); rd = 1'b1;
    for (int k = 0; k < N; k++) set_prod(k, -1, 16 * k);
    run_cycles(6);
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant_id", 32'(rg1[i]), 32'(exp_rr1[i]));
      chk("rr_wr_en", 32'(rw1[i]), 32'd1);
      chk("rr_b4_grant_id", 32'(rg4[i]), 32'(exp_rr4[i]));
    end

    // Full stall against depth-8 FIFO, then resume mid-tenure
    flush(); do_reset(); rd = 1'b0; wlog.delete();
    set_prod(0, 14, 8'h30);
    run_cycles(14);
    chk("stall_writes", 32'(wlog.size()), 32'd8);
    chk("stall_last_data", 32'(logat(7)), 32'h37);
    chk("stall_wr_low", 32'(rw4[13]), 32'd0);
    chk("stall_grant_valid", 32'(rgv4[13]), 32'd1);
    chk("stall_grant_id", 32'(rg4[13]), 32'd0);
    rd = 1'b1; run_cycles(2);
    rd = 1'b0; run_cycles(4);
    chk("resume_writes", 32'(wlog.size()), 32'd10);
    chk("resume_data", 32'(logat(9)), 32'h39);
    chk("stall_keeps_lock", 32'(rl4[3]), 32'd1);
    set_prod(1, -1, 8'hC0); rd = 1'b1;
    run_cycles(8);
    for (int i = 0; i < 7; i++) chk("resume_seq", 32'(logat(10 + i)), 32'(exp_res[i]));

    // Early release
    flush(); do_reset(); rd = 1'b1; wlog.delete();
    set_prod(0, 2, 8'h50); set_prod(2, -1, 8'h70);
    run_cycles(8);
    for (int i = 0; i < 4; i++) begin
      chk("release_grant_id", 32'(rg4[i]), 32'(exp_er[i]));
      chk("release_wr_en", 32'(rw4[i]), 32'd1);
    end
    chk("release_data", 32'(logat(2)), 32'h70);
    chk("release_locked", 32'(rl4[5]), 32'd1);
    chk("release_tenure_end", 32'(rl4[6]), 32'd0);

    // Asynchronous reset during producer 1's third beat
    flush(); do_reset(); rd = 1'b1; wlog.delete();
    set_prod(1, -1, 8'h90);
    run_cycles(2);
    #1;
    chk("pre_reset_wr_en", 32'(wr4), 32'd1);
    chk("pre_reset_grant_id", 32'(g4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_wr_en", 32'(wr4), 32'd0);
    chk("async_reset_ready", 32'(rdy4), 32'd0);
    @(posedge clk); #1;
    chk("no_partial_beat", 32'(wlog.size()), 32'd2);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) set_prod(k, -1, 8'hE0 + k);
    run_cycles(3);
    chk("post_reset_grant_id", 32'(rg4[0]), 32'd0);
    chk("post_reset_wr_en", 32'(rw4[0]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
